// File: rtl/fbrc_down_sync.sv
//------------------------------------------------------------------------------
// Module   : fbrc_down_sync
// Brief    : WIDTH-bit synchronous down counter with a toggle-enable chain,
//            parallel load, cascadable terminal count and sticky underflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fbrc_down_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             uflow
);

    logic [WIDTH-1:0] r_q;
    logic             r_uflow;
    logic [WIDTH-1:0] w_zero_below;
    logic [WIDTH-1:0] w_tog;
    logic             w_all_zero;

    // w_zero_below[i] is high when every bit below i is zero, so bit i borrows.
    assign w_zero_below[0] = 1'b1;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_zero_below[i] = w_zero_below[i-1] & ~r_q[i-1];
        end
    endgenerate

    assign w_tog      = {WIDTH{en}} & w_zero_below;
    assign w_all_zero = w_zero_below[WIDTH-1] & ~r_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_uflow <= 1'b0;
        end else if (load) begin
            r_q     <= d;
            r_uflow <= 1'b0;
        end else begin
            r_q <= r_q ^ w_tog;
            if (en && w_all_zero) begin
                r_uflow <= 1'b1;
            end
        end
    end

    assign q     = r_q;
    assign uflow = r_uflow;
    assign tc    = en & w_all_zero;

endmodule

`default_nettype wire

// File: tb/tb_fbrc_down_sync.sv
//------------------------------------------------------------------------------
// Module   : tb_fbrc_down_sync
// Brief    : Self-checking bench for fbrc_down_sync (table, cascade, random).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fbrc_down_sync;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc, uflow;

    logic         c_rst, c_load, l_en;
    logic [W-1:0] q_lo, q_hi;
    logic         tc_lo, tc_hi, uf_lo, uf_hi;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fbrc_down_sync #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .q(q), .tc(tc), .uflow(uflow)
    );

    fbrc_down_sync #(.WIDTH(W)) u_lo (
        .clk(clk), .reset(c_rst), .en(l_en), .load(c_load), .d(4'h0),
        .q(q_lo), .tc(tc_lo), .uflow(uf_lo)
    );

    fbrc_down_sync #(.WIDTH(W)) u_hi (
        .clk(clk), .reset(c_rst), .en(tc_lo), .load(c_load), .d(4'h0),
        .q(q_hi), .tc(tc_hi), .uflow(uf_hi)
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic         ld;
        logic [W-1:0] d;
        logic [W-1:0] eq;
        logic         euf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic r, input logic e, input logic l,
                        input logic [W-1:0] dv, input logic [W-1:0] eq, input logic euf);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.d = dv; v.eq = eq; v.euf = euf;
        tbl.push_back(v);
    endtask

    int          mq;
    bit          muf;
    logic [7:0]  exp8;

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; d = '0;
        c_rst = 1'b0; c_load = 1'b0; l_en = 1'b0;

        push(1, 1, 1, 4'hA, 4'h0, 0);
        for (int i = 1; i <= 16; i++) push(0, 1, 0, 4'h0, 4'((16 - i) % 16), 1);
        push(0, 1, 1, 4'h3, 4'h3, 0);
        push(0, 1, 1, 4'h9, 4'h9, 0);
        push(0, 1, 0, 4'h0, 4'h8, 0);
        push(0, 1, 0, 4'h0, 4'h7, 0);
        push(0, 0, 1, 4'h5, 4'h5, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 0, 4'h0, 4'h5, 0);
        push(0, 1, 0, 4'h0, 4'h4, 0);
        push(0, 0, 1, 4'hB, 4'hB, 0);
        push(0, 1, 0, 4'h0, 4'hA, 0);
        push(1, 1, 0, 4'h0, 4'h0, 0);
        push(0, 1, 0, 4'h0, 4'hF, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; en = tbl[i].en; load = tbl[i].ld; d = tbl[i].d;
            @(posedge clk);
            #1;
            check("tbl_q", 32'(q), 32'(tbl[i].eq));
            check("tbl_uflow", 32'(uflow), 32'(tbl[i].euf));
            check("tbl_tc", 32'(tc), 32'(tbl[i].en && (tbl[i].eq == 0)));
        end

        // Cascade: two 4-bit stages form an 8-bit down counter.
        @(negedge clk);
        c_load = 1'b1; l_en = 1'b0;
        @(posedge clk);
        #1;
        check("casc_load", 32'({q_hi, q_lo}), 32'h00);
        @(negedge clk);
        c_load = 1'b0; l_en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            exp8 = 8'((256 - k) % 256);
            check("casc_q", 32'({q_hi, q_lo}), 32'(exp8));
        end
        @(negedge clk);
        l_en = 1'b0;

        // Randomized run against an arithmetic reference model.
        @(negedge clk);
        reset = 1'b1; load = 1'b0; en = 1'b0;
        @(posedge clk);
        mq = 0; muf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            d     = W'($urandom);
            #1;
            check("rnd_tc", 32'(tc), 32'(en && (mq == 0)));
            if (reset) begin
                mq = 0; muf = 1'b0;
            end else if (load) begin
                mq = int'(d); muf = 1'b0;
            end else if (en) begin
                if (mq == 0) muf = 1'b1;
                mq = (mq + (1 << W) - 1) % (1 << W);
            end
            @(posedge clk);
            #1;
            check("rnd_q", 32'(q), 32'(mq));
            check("rnd_uflow", 32'(uflow), 32'(muf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fbrc_down_sync.md
Name: fbrc_down_sync

Overview:
- Synchronous WIDTH-bit binary down counter; the count-down counterpart of the team's 4-bit synchronous up counter.
- Built from a toggle-enable chain, so every bit changes on the same clock edge.
- Adds parallel load, count enable, a cascadable terminal-count output and a sticky underflow flag.
- Used as a programmable divider / timeout timer; wider counts are built by chaining tc into the next stage's en.

Parameters:
WIDTH, 4, counter width in bits (>= 2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; decrement by one when high
load  input  1  parallel load strobe
d  input  WIDTH  parallel load value
q  output  WIDTH  current count (registered)
tc  output  1  terminal count / borrow-out, combinational: en & (q == 0)
uflow  output  1  sticky underflow flag (registered)

Behaviour:
- Reset:
  - Synchronous and active-high: sampled only on the rising clk edge. No asynchronous path.
  - The reset edge gives q = 0 and uflow = 0.
  - tc = en at that point, since q == 0.
- Priority on each rising edge: reset > load > en > hold.
- Load:
  - load = 1 (reset = 0): q <= d and uflow <= 0, regardless of en.
  - A simultaneous count request is discarded.
- Count:
  - load = 0, en = 1: q <= (q - 1) mod 2^WIDTH.
  - Wrap-around is 0 -> 2^WIDTH - 1 (4'h0 -> 4'hF for WIDTH = 4).
- Hold: en = 0, load = 0 gives q and uflow unchanged.
- Toggle structure:
  - Bit 0 toggles when en = 1.
  - Bit i toggles when en = 1 and q[i-1:0] == 0 (AND chain of inverted lower bits, mirroring the up counter's AND chain of true bits).
  - All bits are clocked by the same clk; there is no ripple clocking.
  - The RTL may use the T-FF chain or a behavioural subtract, but the cycle behaviour must be identical.
- tc:
  - Purely combinational from q and en; no added latency.
  - High exactly during the cycle whose edge will wrap q from 0 to all-ones.
  - Cascade rule: upper stage en = lower stage tc, which gives a correct 2*WIDTH-bit down counter with no extra cycle.
- uflow:
  - Set on the edge where q wraps (en = 1, load = 0, q == 0).
  - Cleared only by reset or load. Stays set through further counting.
- Latency: q reflects load/count one clock after the qualifying edge's inputs are sampled. Output is visible immediately after the edge.
- Reset mid-count: the count is abandoned. The next edge with reset = 1 forces q = 0 and uflow = 0, even if load or en is high.
- No X propagation: q is defined after the first reset edge. Behaviour before the first reset is undefined and not checked.

Test Plan:
- Reset: reset = 1 for 1 edge with en = 1, load = 1, d = 4'hA -> q = 4'h0, uflow = 0; with en = 1, tc = 1.
- Full count-down: after reset, en = 1 for 16 edges -> q sequence F, E, D, ..., 1, 0. uflow goes 1 after the first edge (wrap from 0) and stays 1. tc is high only in cycles where q = 0.
- Load priority: q = 4'h3, load = 1, en = 1, d = 4'h9 -> next q = 4'h9 (not 4'h2), uflow cleared to 0. Next 2 edges with en = 1 -> 8, 7.
- Hold: q = 4'h5, en = 0 for 3 edges -> q stays 5, tc = 0. Then en = 1 -> q = 4.
- Cascade: two instances with upper.en = lower.tc, both loaded with 0, lower en = 1 for 1 edge -> combined {upper, lower} = 8'hFF. Then 255 more edges -> 8'h00 with no skipped or duplicated states.
- Reset mid-count: q = 4'hB counting, assert reset for 1 edge with en = 1 -> q = 0, uflow = 0. Release -> next edge q = 4'hF, uflow = 1.
